alu_issue_ctrl: RTL and testbench

- EX-stage issue/capture controller that drives the 32-bit ALU (a, b, 4-bit ALUControl) and collects ALUOut/Zeroflag.
- Decodes ALUOp/funct from ID/EX, holds ALU inputs stable for the op's latency, then registers the result into an EX/MEM-facing output register.
- Uses valid/ready on both sides so the pipeline can stall on multi-cycle div/mult and downstream back-pressure.

---
 rtl/alu_issue_ctrl.sv | 127 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - EX-stage ALU issue/capture controller
// Decodes ALUOp/funct, holds ALU operands for the op latency, registers result.
module alu_issue_ctrl #(
  parameter int DATA_W     = 32,
  parameter int MULDIV_LAT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        alu_op,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_zero,
  output logic              out_illegal
);

  typedef enum logic {IDLE, EXEC} state_t;

  localparam logic [3:0] LAT_M1 = 4'(MULDIV_LAT - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       ill_q;
  logic [3:0] dec_ctrl;
  logic       dec_ill;
  logic       accept;
  logic       capture;

  always_comb begin
    dec_ctrl = 4'b0100;
    dec_ill  = 1'b0;
    case (alu_op)
      2'b00: dec_ctrl = 4'b0010;
      2'b01: dec_ctrl = 4'b0110;
      2'b11: dec_ctrl = 4'b0001;
      default: begin
        case (funct)
          6'b100000: dec_ctrl = 4'b0010;
          6'b100010: dec_ctrl = 4'b0110;
          6'b100100: dec_ctrl = 4'b0000;
          6'b100101: dec_ctrl = 4'b0001;
          6'b100111: dec_ctrl = 4'b1100;
          6'b101010: dec_ctrl = 4'b0111;
          6'b011010: dec_ctrl = 4'b1110;
          6'b011000: dec_ctrl = 4'b1111;
          default: begin
            dec_ctrl = 4'b0100;
            dec_ill  = 1'b1;
          end
        endcase
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        // Capture only once the hold count expires and the output slot is free.
        if (cnt == 4'd0 && (!out_valid || out_ready)) begin
          capture   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= 4'd0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_ctrl    <= 4'd0;
      ill_q       <= 1'b0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_zero    <= 1'b0;
      out_illegal <= 1'b0;
    end else begin
      if (accept) begin
        alu_a    <= src_a;
        alu_b    <= src_b;
        alu_ctrl <= dec_ctrl;
        ill_q    <= dec_ill;
        cnt      <= (dec_ctrl[3:1] == 3'b111) ? LAT_M1 : 4'd0;
      end else if (state == EXEC && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end

      if (capture) begin
        out_valid   <= 1'b1;
        out_result  <= alu_out;
        out_zero    <= alu_zero;
        out_illegal <= ill_q;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - scoreboard bench for alu_issue_ctrl
// Stimulus pushes hand-computed results; a negedge monitor pops on each handshake.
module tb_alu_issue_ctrl;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    alu_op;
  logic [5:0]    funct;
  logic [DW-1:0] src_a, src_b;
  logic [DW-1:0] alu_a, alu_b;
  logic [3:0]    alu_ctrl;
  logic [DW-1:0] alu_out;
  logic          alu_zero;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_result;
  logic          out_zero;
  logic          out_illegal;

  typedef struct packed {
    logic [DW-1:0] result;
    logic          zero;
    logic          illegal;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DATA_W(DW), .MULDIV_LAT(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .src_a(src_a), .src_b(src_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_illegal(out_illegal)
  );

  // External ALU that the controller drives.
  always_comb begin
    alu_out = '0;
    case (alu_ctrl)
      4'b0010: alu_out = alu_a + alu_b;
      4'b0110: alu_out = alu_a - alu_b;
      4'b0000: alu_out = alu_a & alu_b;
      4'b0001: alu_out = alu_a | alu_b;
      4'b1100: alu_out = ~(alu_a | alu_b);
      4'b0111: alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
      4'b1110: alu_out = (alu_b != 0) ? alu_a / alu_b : '0;
      4'b1111: alu_out = alu_a * alu_b;
      default: alu_out = '0;
    endcase
    alu_zero = (alu_out == '0);
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_result: got 0x%0h, expected no result", out_result);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("mon_result", out_result, e.result);
        check("mon_zero", {31'd0, out_zero}, {31'd0, e.zero});
        check("mon_illegal", {31'd0, out_illegal}, {31'd0, e.illegal});
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [5:0] fn,
                       input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic acc;
    int   n;
    alu_op = op; funct = fn; src_a = a; src_b = b; in_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      @(negedge clk) acc = in_ready;
      @(posedge clk) #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      total_cnt++;
      $display("FAIL issue_timeout: got in_ready=0 for 50 cycles, expected accept");
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk) #1;
    end
  endtask

  function automatic exp_t mk(input logic [DW-1:0] r, input logic z, input logic il);
    exp_t e;
    e.result = r; e.zero = z; e.illegal = il;
    return e;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; alu_op = 2'b00; funct = 6'd0;
    src_a = '0; src_b = '0; out_ready = 1'b1;
    tick(2);
    reset = 1'b0;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_zero_ill", {30'd0, out_zero, out_illegal}, 32'd0);

    // add 5+7
    exp_q.push_back(mk(32'd12, 1'b0, 1'b0));
    issue(2'b10, 6'b100000, 32'd5, 32'd7);
    check("add_ctrl", {28'd0, alu_ctrl}, 32'b0010);
    check("add_in_ready_low", {31'd0, in_ready}, 32'd0);
    check("add_not_yet_valid", {31'd0, out_valid}, 32'd0);
    tick(1);
    check("add_valid_1edge", {31'd0, out_valid}, 32'd1);
    tick(1);

    // beq compare
    exp_q.push_back(mk(32'd0, 1'b1, 1'b0));
    issue(2'b01, 6'b000000, 32'h1234, 32'h1234);
    check("beq_ctrl", {28'd0, alu_ctrl}, 32'b0110);
    tick(2);

    // mult 6*7 with 4-cycle hold
    exp_q.push_back(mk(32'd42, 1'b0, 1'b0));
    issue(2'b10, 6'b011000, 32'd6, 32'd7);
    check("mul_ctrl", {28'd0, alu_ctrl}, 32'b1111);
    for (int k = 1; k <= 3; k++) begin
      tick(1);
      check("mul_hold_valid", {31'd0, out_valid}, 32'd0);
      check("mul_hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("mul_hold_ctrl", {28'd0, alu_ctrl}, 32'b1111);
    end
    tick(1);
    check("mul_valid_4edge", {31'd0, out_valid}, 32'd1);
    tick(1);

    // back-pressure: sub 9-4 held, or 1|2 stalls in EXEC
    out_ready = 1'b0;
    exp_q.push_back(mk(32'd5, 1'b0, 1'b0));
    issue(2'b01, 6'b000000, 32'd9, 32'd4);
    tick(1);
    check("bp_first_valid", {31'd0, out_valid}, 32'd1);
    exp_q.push_back(mk(32'd3, 1'b0, 1'b0));
    issue(2'b11, 6'b000000, 32'd1, 32'd2);
    for (int k = 0; k < 3; k++) begin
      check("bp_hold_result", out_result, 32'd5);
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold_ctrl", {28'd0, alu_ctrl}, 32'b0001);
      check("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
      tick(1);
    end
    out_ready = 1'b1;
    tick(1);
    check("bp_reload_result", out_result, 32'd3);
    check("bp_reload_valid", {31'd0, out_valid}, 32'd1);
    tick(1);

    // illegal funct
    exp_q.push_back(mk(32'd0, 1'b1, 1'b1));
    issue(2'b10, 6'b111111, 32'hdead, 32'hbeef);
    check("ill_ctrl", {28'd0, alu_ctrl}, 32'b0100);
    tick(2);

    // slt 3<5
    exp_q.push_back(mk(32'd1, 1'b0, 1'b0));
    issue(2'b10, 6'b101010, 32'd3, 32'd5);
    check("slt_ctrl", {28'd0, alu_ctrl}, 32'b0111);
    tick(2);

    // div 20/4 runs to completion
    exp_q.push_back(mk(32'd5, 1'b0, 1'b0));
    issue(2'b10, 6'b011010, 32'd20, 32'd4);
    check("div_ctrl", {28'd0, alu_ctrl}, 32'b1110);
    tick(5);

    // reset two cycles into a div: result must never appear
    issue(2'b10, 6'b011010, 32'd100, 32'd5);
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("rstdiv_out_valid", {31'd0, out_valid}, 32'd0);
    check("rstdiv_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
    check("rstdiv_in_ready", {31'd0, in_ready}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      tick(1);
      check("rstdiv_no_stale", {31'd0, out_valid}, 32'd0);
    end

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
